// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Conditions the raw player buttons for the game core. Every raw input goes
// through a two-flop synchronizer and then an independent counter-based
// debouncer. The debounced buttons drive a small FSM that accepts a play only
// when exactly one button is pressed. A press with two or more buttons is
// rejected and flagged on multipla. After either outcome the FSM waits for all
// buttons to be released before it will accept another press. The start
// (jogar) and confirm (confirma) buttons each produce a one-cycle pulse on
// their debounced rising edge.
//
// Parameters
//   N_DEB        consecutive stable cycles before a debounced value changes
//                (legal range 2..65535)
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous reset, active low
//   botoes_in    raw button levels, 1 = pressed
//   jogar_in     raw start button
//   confirma_in  raw confirm button
//   botoes       one-hot code of the last accepted play (held)
//   tem_jogada   one-cycle pulse, a new play was accepted
//   jogar        one-cycle pulse on the debounced jogar_in rising edge
//   confirma     one-cycle pulse on the debounced confirma_in rising edge
//   multipla     one-cycle pulse, a multi-button press was rejected
//
// Optional debug build (define CONDICIONADOR_BOTOES_DEBUG_EN)
//   db_estado    FSM state (LIVRE=00, ACEITA=01, ESPERA_SOLTAR=10)
//   db_filtrados debounced button levels
// -----------------------------------------------------------------------------
module condicionador_botoes #(
  parameter int N_DEB = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       jogar_in,
  input  logic       confirma_in,
  output logic [3:0] botoes,
  output logic       tem_jogada,
  output logic       jogar,
  output logic       confirma,
  output logic       multipla
`ifdef CONDICIONADOR_BOTOES_DEBUG_EN
  ,
  output logic [1:0] db_estado,
  output logic [3:0] db_filtrados
`endif
);

  localparam int          N_CH    = 6;
  localparam logic [15:0] CNT_MAX = 16'(N_DEB - 1);

  // Channel layout: [3:0] buttons, [4] jogar, [5] confirma.
  localparam int CH_JOGAR    = 4;
  localparam int CH_CONFIRMA = 5;

  typedef enum logic [1:0] {
    LIVRE         = 2'b00,
    ACEITA        = 2'b01,
    ESPERA_SOLTAR = 2'b10
  } estado_t;

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] sync_p0;
  logic [N_CH-1:0] sync_p1;
  logic [N_CH-1:0] filt_p2;
  logic [15:0]     cnt_p2 [N_CH];
  logic [1:0]      filt_p3;

  estado_t         estado;
  estado_t         estado_next;
  logic            carrega;
  logic            multipla_next;
  logic [3:0]      filt_botoes;
  logic            um_botao;
  logic            varios_botoes;

  assign raw = {confirma_in, jogar_in, botoes_in};

  // ---- stage p0/p1: two-flop synchronizer ----------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-channel debounce --------------------------------------
  // The counter only runs while the synchronized level disagrees with the
  // filtered level; any agreement (a glitch ending) restarts it from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_p2 <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          filt_p2[i] <= sync_p1[i];
          cnt_p2[i]  <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 16'd1;
        end
      end
    end
  end

  // ---- stage p3: rising-edge pulses for jogar / confirma -------------------
  // The delayed copy makes each pulse land one cycle after the filtered
  // level rises, aligned with the FSM's registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_p3  <= '0;
      jogar    <= 1'b0;
      confirma <= 1'b0;
    end else begin
      filt_p3  <= {filt_p2[CH_CONFIRMA], filt_p2[CH_JOGAR]};
      jogar    <= filt_p2[CH_JOGAR]    & ~filt_p3[0];
      confirma <= filt_p2[CH_CONFIRMA] & ~filt_p3[1];
    end
  end

  // ---- stage p3: button FSM ------------------------------------------------
  assign filt_botoes   = filt_p2[3:0];
  assign um_botao      = (filt_botoes != 4'b0000) &&
                         ((filt_botoes & (filt_botoes - 4'd1)) == 4'b0000);
  assign varios_botoes = (filt_botoes != 4'b0000) && !um_botao;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= LIVRE;
    end else begin
      estado <= estado_next;
    end
  end

  always_comb begin
    estado_next   = estado;
    carrega       = 1'b0;
    multipla_next = 1'b0;
    unique case (estado)
      LIVRE: begin
        if (um_botao) begin
          carrega     = 1'b1;
          estado_next = ACEITA;
        end else if (varios_botoes) begin
          multipla_next = 1'b1;
          estado_next   = ESPERA_SOLTAR;
        end
      end
      ACEITA: begin
        estado_next = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        // Extra presses while waiting are ignored; only a full release
        // re-arms the FSM.
        if (filt_botoes == 4'b0000) begin
          estado_next = LIVRE;
        end
      end
      default: begin
        estado_next = LIVRE;
      end
    endcase
  end

  // The accepted code is held until the next accepted play; the rejection
  // flag is registered so it rises together with the move into
  // ESPERA_SOLTAR, the same timing as tem_jogada for an accepted play.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes   <= 4'b0000;
      multipla <= 1'b0;
    end else begin
      multipla <= multipla_next;
      if (carrega) begin
        botoes <= filt_botoes;
      end
    end
  end

  assign tem_jogada = (estado == ACEITA);

`ifdef CONDICIONADOR_BOTOES_DEBUG_EN
  assign db_estado    = estado;
  assign db_filtrados = filt_botoes;
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botoes
//
// Directed bench for condicionador_botoes with N_DEB=4. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising
// edge. Cycle numbers count rising edges since the stimulus was applied, so a
// value applied before edge 1 is first sampled by edge 1.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;

  localparam int N_DEB = 4;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_in;
  logic       jogar_in;
  logic       confirma_in;
  logic [3:0] botoes;
  logic       tem_jogada;
  logic       jogar;
  logic       confirma;
  logic       multipla;

  int checks;
  int failures;

  int cyc;
  int tem_cnt, tem_first;
  int mul_cnt, mul_first;
  int jog_cnt, jog_first;
  int con_cnt, con_first;

  condicionador_botoes #(.N_DEB(N_DEB)) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes_in   (botoes_in),
    .jogar_in    (jogar_in),
    .confirma_in (confirma_in),
    .botoes      (botoes),
    .tem_jogada  (tem_jogada),
    .jogar       (jogar),
    .confirma    (confirma),
    .multipla    (multipla)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cyc       = 0;
    tem_cnt   = 0; tem_first = 0;
    mul_cnt   = 0; mul_first = 0;
    jog_cnt   = 0; jog_first = 0;
    con_cnt   = 0; con_first = 0;
  endtask

  // Advance n rising edges, logging every pulse seen and the cycle of the
  // first one.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (tem_jogada) begin tem_cnt++; if (tem_first == 0) tem_first = cyc; end
      if (multipla)   begin mul_cnt++; if (mul_first == 0) mul_first = cyc; end
      if (jogar)      begin jog_cnt++; if (jog_first == 0) jog_first = cyc; end
      if (confirma)   begin con_cnt++; if (con_first == 0) con_first = cyc; end
    end
  endtask

  // Returns at a falling edge with reset just released and inputs idle.
  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    botoes_in   = 4'b0000;
    jogar_in    = 1'b0;
    confirma_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_counts();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    botoes_in   = 4'b0000;
    jogar_in    = 1'b0;
    confirma_in = 1'b0;
    clear_counts();

    // Reset state, with raw inputs active to show reset dominates.
    @(negedge clock);
    botoes_in   = 4'b0001;
    jogar_in    = 1'b1;
    confirma_in = 1'b1;
    repeat (8) @(negedge clock);
    chk("rst_botoes",   botoes,     4'b0000);
    chk("rst_tem",      tem_jogada, 1'b0);
    chk("rst_jogar",    jogar,      1'b0);
    chk("rst_confirma", confirma,   1'b0);
    chk("rst_multipla", multipla,   1'b0);

    // Single button held: one play, accepted on edge 7, code held after release.
    do_reset();
    botoes_in = 4'b0010;
    cycles(20);
    chk("one_tem_cnt",   tem_cnt,   1);
    chk("one_tem_first", tem_first, 7);
    chk("one_mul_cnt",   mul_cnt,   0);
    chk("one_botoes",    botoes,    4'b0010);
    botoes_in = 4'b0000;
    cycles(15);
    chk("one_rel_tem_cnt", tem_cnt, 1);
    chk("one_rel_botoes",  botoes,  4'b0010);

    // Glitch shorter than N_DEB: nothing happens.
    do_reset();
    botoes_in = 4'b0001;
    cycles(3);
    botoes_in = 4'b0000;
    cycles(15);
    chk("glitch_tem_cnt", tem_cnt, 0);
    chk("glitch_botoes",  botoes,  4'b0000);

    // Two buttons: rejected, then a clean single press is accepted.
    do_reset();
    botoes_in = 4'b0101;
    cycles(20);
    chk("multi_mul_cnt",   mul_cnt,   1);
    chk("multi_mul_first", mul_first, 7);
    chk("multi_tem_cnt",   tem_cnt,   0);
    chk("multi_botoes",    botoes,    4'b0000);
    botoes_in = 4'b0000;
    cycles(12);
    clear_counts();
    botoes_in = 4'b1000;
    cycles(20);
    chk("after_multi_tem_cnt",   tem_cnt,   1);
    chk("after_multi_tem_first", tem_first, 7);
    chk("after_multi_mul_cnt",   mul_cnt,   0);
    chk("after_multi_botoes",    botoes,    4'b1000);

    // Button added while waiting for release is ignored.
    do_reset();
    botoes_in = 4'b0100;
    cycles(15);
    botoes_in = 4'b0101;
    cycles(15);
    chk("add_botoes_mid", botoes, 4'b0100);
    botoes_in = 4'b0000;
    cycles(15);
    botoes_in = 4'b0100;
    cycles(15);
    chk("add_tem_cnt", tem_cnt, 2);
    chk("add_mul_cnt", mul_cnt, 0);
    chk("add_botoes",  botoes,  4'b0100);

    // jogar and confirma together: one pulse each, same cycle, none on release.
    do_reset();
    jogar_in    = 1'b1;
    confirma_in = 1'b1;
    cycles(20);
    chk("jc_jog_cnt",   jog_cnt,   1);
    chk("jc_con_cnt",   con_cnt,   1);
    chk("jc_jog_first", jog_first, 7);
    chk("jc_con_first", con_first, 7);
    chk("jc_tem_cnt",   tem_cnt,   0);
    jogar_in    = 1'b0;
    confirma_in = 1'b0;
    cycles(15);
    chk("jc_rel_jog_cnt", jog_cnt, 1);
    chk("jc_rel_con_cnt", con_cnt, 1);

    // Reset after debounce but before ACEITA, then re-accept after release.
    do_reset();
    botoes_in = 4'b0010;
    cycles(6);
    chk("mid_tem_before", tem_cnt, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_botoes", botoes,     4'b0000);
    chk("mid_rst_tem",    tem_jogada, 1'b0);
    chk("mid_rst_mul",    multipla,   1'b0);
    repeat (3) @(negedge clock);
    chk("mid_rst_hold_tem", tem_jogada, 1'b0);
    reset = 1'b1;
    clear_counts();
    cycles(12);
    chk("mid_tem_cnt",   tem_cnt,   1);
    chk("mid_tem_first", tem_first, N_DEB + 3);
    chk("mid_botoes",    botoes,    4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
